uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit; legal values are even and >= 4.
REQ-002 SHALL have port: clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: rx  input  1  asynchronous serial line; idles high; 8N1 framing, LSB first.
REQ-005 SHALL have port: rx_data  output  8  last correctly received byte.
REQ-006 SHALL have port: rx_valid  output  1  one-cycle pulse; rx_data has just been updated.
REQ-007 SHALL have port: rx_busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port: frame_err  output  1  one-cycle pulse; the stop bit was sampled low.
REQ-009 SHALL have port: parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1; all decisions use the synchronized value rx_s.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (present only with the parity macro), STOP and WAIT_HIGH.
REQ-012 IDLE: rx_s == 0 SHALL move to START with the bit counter cleared.
REQ-013 START: at count CLKS_PER_BIT/2-1, rx_s == 0 SHALL move to DATA; rx_s == 1 is a glitch and SHALL return to IDLE with no output pulse.
REQ-014 DATA: SHALL sample rx_s every CLKS_PER_BIT cycles, i.e. at each bit centre.
- Bits shift in LSB first.
- The 3-bit index moves to the next state after bit 7.
REQ-015 STOP: SHALL sample at the stop-bit centre.
- rx_s == 1: load rx_data and pulse rx_valid in the next cycle, then go to IDLE.
- rx_s == 0: pulse frame_err, leave rx_data unchanged, go to WAIT_HIGH.
REQ-016 WAIT_HIGH: SHALL stay until rx_s == 1, then go to IDLE; a held-low line (break) produces exactly one frame_err.
REQ-017 SHALL accept back-to-back frames: a start edge arriving in the second half of a stop bit is detected from IDLE.
REQ-018 rx_valid, frame_err and parity_err SHALL never be high in the same cycle, and none SHALL be high for more than one cycle.
REQ-019 rx_data SHALL hold its value between rx_valid pulses.

Reset
REQ-020 Reset values SHALL be: state IDLE, counters 0, rx_data 8'h00, rx_valid 0, rx_busy 0, frame_err 0, parity_err 0, synchronizer 1.
REQ-021 Reset asserted mid-frame SHALL abort the frame at the next clock edge with no output pulse; reception restarts only on a new falling edge after reset is released.

Configuration
REQ-022 Macro UART_RX_PARITY_EN, when defined, SHALL enable the PARITY state after DATA, sampling one even-parity bit at its centre.
- Mismatch: pulse parity_err, leave rx_data unchanged, still check the stop bit, do not pulse rx_valid.
- If the stop bit is also low, only frame_err is pulsed.
REQ-023 Without UART_RX_PARITY_EN, the frame SHALL be 8N1, the PARITY state SHALL not exist, and parity_err SHALL be constant 0.

Verification (CLKS_PER_BIT=16, 10 ns clock)
REQ-024 Drive 0xA5 as 8N1 at 160 ns/bit -> rx_data = 8'hA5 and exactly one rx_valid pulse within 2 bit times after the stop-bit centre; rx_busy low afterwards.
REQ-025 Drive 0x3C immediately followed by 0xC3 with no idle gap -> two rx_valid pulses, with rx_data = 8'h3C then 8'hC3.
REQ-026 Drive a 50 ns low glitch on an idle line -> no rx_valid or frame_err pulse; rx_busy returns to 0 within 8 cycles of the glitch being detected.
REQ-027 Drive 0x55 with the stop bit low, then hold rx low for 40 bit times -> one frame_err pulse; rx_data keeps its previous value; rx_busy stays high until rx rises.
REQ-028 Assert reset for 1 cycle during bit 4 of a frame, then send 0x81 -> no pulse for the aborted frame; rx_data = 8'h81 with one rx_valid.
REQ-029 With UART_RX_PARITY_EN defined, send 0x07 with a correct parity bit and then a wrong one -> first frame gives rx_valid with rx_data = 8'h07; second frame gives one parity_err pulse only.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus receive results for one UART receiver.
// Latency: none, wires only.
// Backpressure: none; the receiver pulses results and the consumer must take them.
interface uart_rx_if;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;
   logic       parity_err;

   // The receiver reads the line and reports results.
   modport slave (
      input  rx,
      output rx_data,
      output rx_valid,
      output rx_busy,
      output frame_err,
      output parity_err
   );

   // The line driver / result consumer side.
   modport master (
      output rx,
      input  rx_data,
      input  rx_valid,
      input  rx_busy,
      input  frame_err,
      input  parity_err
   );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver; define UART_RX_PARITY_EN for an even-parity bit after the data.
// Latency: result pulse one cycle after the stop-bit centre sample (line seen through a 2-flop sync).
// Backpressure: none; rx_valid/frame_err/parity_err are single-cycle pulses, rx_data holds.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic     clk,
   input  logic     reset,
   uart_rx_if.slave bus
);

   localparam int            CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_HIGH
   } state_t;

   logic          rx_meta;
   logic          rx_s;
   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [2:0]    bit_idx;
   logic [2:0]    idx_nxt;
   logic [7:0]    shift;
   logic [7:0]    shift_nxt;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          ferr_q;
   logic          load;
   logic          ferr_nxt;
`ifdef UART_RX_PARITY_EN
   logic          par_bad;
   logic          par_bad_nxt;
   logic          perr_q;
   logic          perr_nxt;
`endif

   // Bring the asynchronous line into the clock domain; idle-high after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

   // Frame sequencing: start validation, bit-centre sampling, stop check.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_ONE;
      idx_nxt   = bit_idx;
      shift_nxt = shift;
      load      = 1'b0;
      ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_nxt = par_bad;
      perr_nxt    = 1'b0;
`endif
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!rx_s) begin
               state_nxt = START;
               idx_nxt   = '0;
            end
         end
         START: begin
            // Half a bit in: still low means a real start bit, else a glitch.
            if (cnt == HALF_M1) begin
               cnt_nxt   = '0;
               state_nxt = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == FULL_M1) begin
               cnt_nxt   = '0;
               shift_nxt = {rx_s, shift[7:1]};
               idx_nxt   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            // Even parity: the parity bit must equal the XOR of the data bits.
            if (cnt == FULL_M1) begin
               cnt_nxt     = '0;
               par_bad_nxt = rx_s ^ (^shift);
               state_nxt   = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt == FULL_M1) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  // Returning to IDLE at mid-stop lets a back-to-back start edge be seen.
                  state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bad) perr_nxt = 1'b1;
                  else         load     = 1'b1;
`else
                  load = 1'b1;
`endif
               end else begin
                  // A low stop bit wins over a parity mismatch.
                  ferr_nxt  = 1'b1;
                  state_nxt = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            // Sit out a break so a held-low line gives only one frame_err.
            cnt_nxt = '0;
            if (rx_s) state_nxt = IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // State, counters and registered result pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= idx_nxt;
         shift   <= shift_nxt;
         valid_q <= load;
         ferr_q  <= ferr_nxt;
         if (load) data_q <= shift;
`ifdef UART_RX_PARITY_EN
         par_bad <= par_bad_nxt;
         perr_q  <= perr_nxt;
`endif
      end
   end

   assign bus.rx_data   = data_q;
   assign bus.rx_valid  = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.rx_busy   = (state != IDLE);
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = perr_q;
`else
   assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against an expected-event queue for uart_rx.
// Latency: results are matched whenever the DUT pulses, in send order.
// Backpressure: none; the bench only drives the serial line.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int CPB = 16;
   localparam int K_VALID = 0;
   localparam int K_FERR  = 1;
   localparam int K_PERR  = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_rx_if bus();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int         kind;
      logic [7:0] data;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] model_data = 8'h00;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_valid = 0;
   int n_ferr  = 0;
   int n_perr  = 0;
   int last_valid_cyc = 0;
   int stop_start = 0;
   logic rst_q = 1'b1;
   logic pv = 1'b0, pf = 1'b0, pp = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic expect_ev(input int k, input logic [7:0] d);
      ev_t e;
      e.kind = k;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic bit_time(input logic v);
      bus.rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   // Start bit, 8 data bits LSB first, optional even parity (flipped if bad_par), stop bit.
   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
      logic par;
      par = (^d) ^ bad_par;
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
      bit_time(par);
`else
      if (par === 1'bx) bus.rx = 1'b1;
`endif
      stop_start = cyc;
      bit_time(stop);
   endtask

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   // Compare every cycle: pulses are matched against the expected-event queue.
   always @(negedge clk) begin
      ev_t e;
      if (rst_q) begin
         model_data = 8'h00;
         check("reset_pulses", {bus.rx_valid, bus.frame_err, bus.parity_err}, 3'b000);
      end else begin
         check("pulse_onehot", ($countones({bus.rx_valid, bus.frame_err, bus.parity_err}) <= 1), 1);
         if (bus.rx_valid) begin
            check("valid_single_cycle", pv, 0);
            check("valid_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("valid_kind", e.kind, K_VALID);
               check("valid_data", bus.rx_data, e.data);
               model_data = e.data;
            end
            n_valid++;
            last_valid_cyc = cyc;
         end
         if (bus.frame_err) begin
            check("ferr_single_cycle", pf, 0);
            check("ferr_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("ferr_kind", e.kind, K_FERR);
            end
            n_ferr++;
         end
         if (bus.parity_err) begin
            check("perr_single_cycle", pp, 0);
            check("perr_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("perr_kind", e.kind, K_PERR);
            end
            n_perr++;
         end
      end
      check("rx_data_hold", bus.rx_data, model_data);
      pv = bus.rx_valid;
      pf = bus.frame_err;
      pp = bus.parity_err;
   end

   initial begin
      int lat;
      int seen;
      int cleared;
      bus.rx = 1'b1;
      reset  = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_rx_data", bus.rx_data, 8'h00);
      check("reset_busy", bus.rx_busy, 0);
      check("reset_valid", bus.rx_valid, 0);
      check("reset_ferr", bus.frame_err, 0);
      check("reset_perr", bus.parity_err, 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Single frame 0xA5.
      expect_ev(K_VALID, 8'hA5);
      send_frame(8'hA5, 1'b0, 1'b1);
      bit_time(1'b1);
      bit_time(1'b1);
      lat = last_valid_cyc - stop_start;
      check("a5_data", bus.rx_data, 8'hA5);
      check("a5_valid_count", n_valid, 1);
      check("a5_latency_window", (lat >= CPB / 2 && lat <= CPB / 2 + 2 * CPB), 1);
      check("a5_busy_after", bus.rx_busy, 0);

      // Back-to-back 0x3C then 0xC3.
      expect_ev(K_VALID, 8'h3C);
      expect_ev(K_VALID, 8'hC3);
      send_frame(8'h3C, 1'b0, 1'b1);
      send_frame(8'hC3, 1'b0, 1'b1);
      bit_time(1'b1);
      bit_time(1'b1);
      check("b2b_valid_count", n_valid, 3);
      check("b2b_last_data", bus.rx_data, 8'hC3);

      // 50 ns low glitch on an idle line.
      bus.rx = 1'b0;
      seen = -1;
      cleared = -1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (k == 4) bus.rx = 1'b1;
         if (bus.rx_busy && seen < 0) seen = k;
         if (!bus.rx_busy && seen >= 0 && cleared < 0) cleared = k;
      end
      check("glitch_busy_seen", (seen >= 0), 1);
      check("glitch_busy_cleared", (cleared >= 0 && (cleared - seen) <= 8), 1);
      check("glitch_no_valid", n_valid, 3);
      check("glitch_no_ferr", n_ferr, 0);

      // 0x55 with a low stop bit, then a 40-bit break.
      expect_ev(K_FERR, 8'h00);
      send_frame(8'h55, 1'b0, 1'b0);
      for (int b = 0; b < 40; b++) begin
         bit_time(1'b0);
         if (b % 10 == 9) check("break_busy_high", bus.rx_busy, 1);
      end
      bit_time(1'b1);
      bit_time(1'b1);
      check("break_ferr_count", n_ferr, 1);
      check("break_data_kept", bus.rx_data, 8'hC3);
      check("break_busy_low", bus.rx_busy, 0);

      // Reset pulse in the middle of bit 4 of an 0xF0 frame, then 0x81.
      bit_time(1'b0);
      for (int i = 0; i < 4; i++) bit_time(1'b0);
      bus.rx = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (CPB / 2 - 1) @(negedge clk);
      for (int i = 0; i < 4; i++) bit_time(1'b1);
      bit_time(1'b1);
      bit_time(1'b1);
      check("abort_no_valid", n_valid, 3);
      check("abort_rx_data_reset", bus.rx_data, 8'h00);
      expect_ev(K_VALID, 8'h81);
      send_frame(8'h81, 1'b0, 1'b1);
      bit_time(1'b1);
      bit_time(1'b1);
      check("after_reset_data", bus.rx_data, 8'h81);
      check("after_reset_valid_count", n_valid, 4);

`ifdef UART_RX_PARITY_EN
      // 0x07 with good parity, then with bad parity.
      expect_ev(K_VALID, 8'h07);
      send_frame(8'h07, 1'b0, 1'b1);
      bit_time(1'b1);
      expect_ev(K_PERR, 8'h00);
      send_frame(8'h07, 1'b1, 1'b1);
      bit_time(1'b1);
      bit_time(1'b1);
      check("parity_good_data", bus.rx_data, 8'h07);
      check("parity_valid_count", n_valid, 5);
      check("parity_err_count", n_perr, 1);
`else
      check("no_parity_err_pulses", n_perr, 0);
`endif

      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
